// File: rtl/mp_fifo_ptr_update.sv
// Multi-port in-order queue with age-tagged pointers, in-place payload update and tail rollback.
// Head/tail carry a wrap flag in the MSB so a full queue and an empty queue stay distinguishable.
module mp_fifo_ptr_update #(
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int ENQUEUE_WIDTH  = 4,
  parameter int DEQUEUE_WIDTH  = 4,
  parameter int UPDATE_WIDTH   = 2,
  parameter int DEPTH          = 16,
  parameter bit MUST_TAKEN_ALL = 1'b1,
  localparam int PTR_W = $clog2(DEPTH) + 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ENQUEUE_WIDTH-1:0]                     enqueue_vld_i,
  input  logic [ENQUEUE_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  enqueue_payload_i,
  output logic [ENQUEUE_WIDTH-1:0]                     enqueue_rdy_o,
  output logic [ENQUEUE_WIDTH-1:0][PTR_W-1:0]          enq_ptr_o,
  output logic [DEQUEUE_WIDTH-1:0]                     dequeue_vld_o,
  output logic [DEQUEUE_WIDTH-1:0][PAYLOAD_WIDTH-1:0]  dequeue_payload_o,
  input  logic [DEQUEUE_WIDTH-1:0]                     dequeue_rdy_i,
  output logic [DEQUEUE_WIDTH-1:0][PTR_W-1:0]          deq_ptr_o,
  input  logic [UPDATE_WIDTH-1:0]                      upd_vld_i,
  input  logic [UPDATE_WIDTH-1:0][PTR_W-1:0]           upd_ptr_i,
  input  logic [UPDATE_WIDTH-1:0][PAYLOAD_WIDTH-1:0]   upd_payload_i,
  input  logic                                         rollback_vld_i,
  input  logic [PTR_W-1:0]                             rollback_ptr_i,
  input  logic                                         flush_i,
  output logic [CNT_W-1:0]                             avail_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];

  logic [CNT_W-1:0]         count;
  logic [ENQUEUE_WIDTH-1:0] enq_fire;
  logic [ENQUEUE_WIDTH-1:0][IDX_W-1:0] enq_slot;
  logic [PTR_W-1:0]         enq_num;
  logic [PTR_W-1:0]         deq_num;
  logic                     deq_run;
  logic [PTR_W-1:0]         head_nxt;
  logic [PTR_W-1:0]         tail_nxt;
  logic [PTR_W-1:0]         rb_dist;
  logic [PTR_W-1:0]         upd_tail;
  logic [PTR_W-1:0]         upd_lim;
  logic [UPDATE_WIDTH-1:0]  upd_ok;

  // Pointer difference modulo 2*DEPTH is the occupancy, flag included.
  assign count       = CNT_W'(tail - head);
  assign avail_cnt_o = CNT_W'(DEPTH) - count;

  always_comb begin
    enqueue_rdy_o = '0;
    for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
      if (MUST_TAKEN_ALL) enqueue_rdy_o[i] = (avail_cnt_o >= CNT_W'(ENQUEUE_WIDTH));
      else                enqueue_rdy_o[i] = (avail_cnt_o > CNT_W'(i));
    end
    if (flush_i || rollback_vld_i) enqueue_rdy_o = '0;
  end

  always_comb begin
    enq_fire = enqueue_vld_i & enqueue_rdy_o;
    enq_num  = '0;
    enq_slot = '0;
    for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
      enq_ptr_o[i] = tail + PTR_W'(i);
      enq_slot[i]  = IDX_W'(tail + enq_num);
      enq_num      = enq_num + PTR_W'(enq_fire[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < DEQUEUE_WIDTH; i++) begin
      dequeue_vld_o[i]     = (count > CNT_W'(i));
      deq_ptr_o[i]         = head + PTR_W'(i);
      dequeue_payload_o[i] = mem[deq_ptr_o[i][IDX_W-1:0]];
    end
  end

  // Pop only the unbroken run of ready lanes starting at lane 0.
  always_comb begin
    deq_num = '0;
    deq_run = 1'b1;
    for (int i = 0; i < DEQUEUE_WIDTH; i++) begin
      deq_run = deq_run & dequeue_vld_o[i] & dequeue_rdy_i[i];
      deq_num = deq_num + PTR_W'(deq_run);
    end
  end

  assign head_nxt = head + deq_num;
  assign rb_dist  = rollback_ptr_i - head;

  // A dequeue that overtakes the rollback point leaves the queue empty.
  always_comb begin
    if (rollback_vld_i) begin
      if (rb_dist < deq_num) tail_nxt = head_nxt;
      else                   tail_nxt = rollback_ptr_i;
    end else begin
      tail_nxt = tail + enq_num;
    end
  end

  // Updates only land in entries still live after this cycle's pop and rollback.
  always_comb begin
    upd_tail = rollback_vld_i ? tail_nxt : tail;
    upd_lim  = upd_tail - head_nxt;
    for (int u = 0; u < UPDATE_WIDTH; u++) begin
      upd_ok[u] = upd_vld_i[u] && ((upd_ptr_i[u] - head_nxt) < upd_lim);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  // Later update lanes overwrite earlier ones on the same entry.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      for (int i = 0; i < ENQUEUE_WIDTH; i++) begin
        if (enq_fire[i]) mem[enq_slot[i]] <= enqueue_payload_i[i];
      end
      for (int u = 0; u < UPDATE_WIDTH; u++) begin
        if (upd_ok[u]) mem[upd_ptr_i[u][IDX_W-1:0]] <= upd_payload_i[u];
      end
    end
  end

  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  a_rollback_legal: assert property (@(posedge clk) disable iff (rst || flush_i)
    rollback_vld_i |-> (rb_dist <= PTR_W'(count)));
  a_depth_pow2: assert property (@(posedge clk) (DEPTH & (DEPTH - 1)) == 0);

endmodule

// File: tb/tb_mp_fifo_ptr_update.sv
// Directed bench for mp_fifo_ptr_update: vector table plus hand sequences for wrap, flush and reset.
module tb_mp_fifo_ptr_update;
  localparam int PW = 32, EW = 4, DW = 4, UW = 2, PTR_W = 5, CNT_W = 5, NROWS = 19;

  logic clk = 1'b0;
  logic rst;
  logic [EW-1:0]          enqueue_vld_i;
  logic [EW-1:0][PW-1:0]  enqueue_payload_i;
  logic [EW-1:0]          enqueue_rdy_o;
  logic [EW-1:0][PTR_W-1:0] enq_ptr_o;
  logic [DW-1:0]          dequeue_vld_o;
  logic [DW-1:0][PW-1:0]  dequeue_payload_o;
  logic [DW-1:0]          dequeue_rdy_i;
  logic [DW-1:0][PTR_W-1:0] deq_ptr_o;
  logic [UW-1:0]          upd_vld_i;
  logic [UW-1:0][PTR_W-1:0] upd_ptr_i;
  logic [UW-1:0][PW-1:0]  upd_payload_i;
  logic                   rollback_vld_i;
  logic [PTR_W-1:0]       rollback_ptr_i;
  logic                   flush_i;
  logic [CNT_W-1:0]       avail_cnt_o;

  always #5 clk = ~clk;

  mp_fifo_ptr_update dut (
    .clk(clk), .rst(rst),
    .enqueue_vld_i(enqueue_vld_i), .enqueue_payload_i(enqueue_payload_i),
    .enqueue_rdy_o(enqueue_rdy_o), .enq_ptr_o(enq_ptr_o),
    .dequeue_vld_o(dequeue_vld_o), .dequeue_payload_o(dequeue_payload_o),
    .dequeue_rdy_i(dequeue_rdy_i), .deq_ptr_o(deq_ptr_o),
    .upd_vld_i(upd_vld_i), .upd_ptr_i(upd_ptr_i), .upd_payload_i(upd_payload_i),
    .rollback_vld_i(rollback_vld_i), .rollback_ptr_i(rollback_ptr_i),
    .flush_i(flush_i), .avail_cnt_o(avail_cnt_o)
  );

  typedef struct {
    logic [3:0]  enq_vld;
    logic [31:0] enq_base;
    logic [3:0]  deq_rdy;
    logic [1:0]  upd_vld;
    logic [4:0]  upd_ptr0;
    logic [4:0]  upd_ptr1;
    logic [31:0] upd_pay0;
    logic [31:0] upd_pay1;
    logic        rb_vld;
    logic [4:0]  rb_ptr;
    logic        flush;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_vld;
    logic [4:0]  exp_avail;
    logic [4:0]  exp_head;
    logic [4:0]  exp_tail;
    logic [31:0] exp_pay0;
    logic [31:0] exp_pay1;
    logic [31:0] exp_pay2;
    logic [31:0] exp_pay3;
  } vec_t;

  vec_t        tbl [NROWS];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    enqueue_vld_i     = '0;
    enqueue_payload_i = '0;
    dequeue_rdy_i     = '0;
    upd_vld_i         = '0;
    upd_ptr_i         = '0;
    upd_payload_i     = '0;
    rollback_vld_i    = 1'b0;
    rollback_ptr_i    = '0;
    flush_i           = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    enqueue_vld_i = v.enq_vld;
    for (int i = 0; i < EW; i++) enqueue_payload_i[i] = v.enq_base + 32'(i);
    dequeue_rdy_i    = v.deq_rdy;
    upd_vld_i        = v.upd_vld;
    upd_ptr_i[0]     = v.upd_ptr0;
    upd_ptr_i[1]     = v.upd_ptr1;
    upd_payload_i[0] = v.upd_pay0;
    upd_payload_i[1] = v.upd_pay1;
    rollback_vld_i   = v.rb_vld;
    rollback_ptr_i   = v.rb_ptr;
    flush_i          = v.flush;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " avail"}, 32'(avail_cnt_o), 32'd16);
    chk({tag, " vld"}, 32'(dequeue_vld_o), 32'h0);
    chk({tag, " rdy"}, 32'(enqueue_rdy_o), 32'hF);
    chk({tag, " head"}, 32'(deq_ptr_o[0]), 32'h0);
    chk({tag, " tail"}, 32'(enq_ptr_o[0]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ep [4];
    logic [4:0]  head_m, tail_m;
    logic [3:0]  rdy_m, vld_m;
    logic [31:0] nxt;
    int          cnt, pops, nenq;

    //             ev     base      dr    uv     up0    up1    upay0        upay1       rbv   rbp    fl    xrdy  xvld  xav    xhd    xtl    p0        p1        p2        p3
    tbl[0]  = '{4'hF, 32'hA0, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd12, 5'h00, 5'h04, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    tbl[1]  = '{4'h3, 32'hB0, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd10, 5'h00, 5'h06, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    tbl[2]  = '{4'h0, 32'h00, 4'h5, 2'b11, 5'h02, 5'h02, 32'hC0,     32'hC1,     1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd11, 5'h01, 5'h06, 32'hA1, 32'hC1, 32'hA3, 32'hB0};
    tbl[3]  = '{4'h1, 32'hD0, 4'h0, 2'b11, 5'h12, 5'h0A, 32'hDEAD,   32'hBEEF,   1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd10, 5'h01, 5'h07, 32'hA1, 32'hC1, 32'hA3, 32'hB0};
    tbl[4]  = '{4'hF, 32'hEE, 4'hF, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b1, 4'h0, 4'h0, 5'd16, 5'h00, 5'h00, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[5]  = '{4'hF, 32'h10, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd12, 5'h00, 5'h04, 32'h10, 32'h11, 32'h12, 32'h13};
    tbl[6]  = '{4'hF, 32'h14, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd8,  5'h00, 5'h08, 32'h10, 32'h11, 32'h12, 32'h13};
    tbl[7]  = '{4'hF, 32'h99, 4'h3, 2'b11, 5'h06, 5'h04, 32'h66,     32'h44,     1'b1, 5'h05, 1'b0, 4'h0, 4'h7, 5'd13, 5'h02, 5'h05, 32'h12, 32'h13, 32'h44, 32'h0};
    tbl[8]  = '{4'h1, 32'h20, 4'h3, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'h3, 5'd14, 5'h04, 5'h06, 32'h44, 32'h20, 32'h0,  32'h0};
    tbl[9]  = '{4'h0, 32'h00, 4'h3, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b1, 5'h05, 1'b0, 4'h0, 4'h0, 5'd16, 5'h06, 5'h06, 32'h0,  32'h0,  32'h0,  32'h0};
    tbl[10] = '{4'hF, 32'h30, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd12, 5'h06, 5'h0A, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[11] = '{4'h0, 32'h00, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b1, 5'h0A, 1'b0, 4'h0, 4'hF, 5'd12, 5'h06, 5'h0A, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[12] = '{4'hF, 32'h40, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd8,  5'h06, 5'h0E, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[13] = '{4'hF, 32'h50, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd4,  5'h06, 5'h12, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[14] = '{4'h3, 32'h60, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd2,  5'h06, 5'h14, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[15] = '{4'hF, 32'h70, 4'h0, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'h0, 4'hF, 5'd2,  5'h06, 5'h14, 32'h30, 32'h31, 32'h32, 32'h33};
    tbl[16] = '{4'hF, 32'h80, 4'hF, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'h0, 4'hF, 5'd6,  5'h0A, 5'h14, 32'h40, 32'h41, 32'h42, 32'h43};
    tbl[17] = '{4'h0, 32'h00, 4'hF, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'hF, 5'd10, 5'h0E, 5'h14, 32'h50, 32'h51, 32'h52, 32'h53};
    tbl[18] = '{4'h0, 32'h00, 4'hF, 2'b00, 5'h00, 5'h00, 32'h0,      32'h0,      1'b0, 5'h00, 1'b0, 4'hF, 4'h3, 5'd14, 5'h12, 5'h14, 32'h60, 32'h61, 32'h0,  32'h0};

    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");

    for (int r = 0; r < NROWS; r++) begin
      drive(tbl[r]);
      #1;
      chk($sformatf("row%0d rdy", r), 32'(enqueue_rdy_o), 32'(tbl[r].exp_rdy));
      @(negedge clk);
      chk($sformatf("row%0d vld", r), 32'(dequeue_vld_o), 32'(tbl[r].exp_vld));
      chk($sformatf("row%0d avail", r), 32'(avail_cnt_o), 32'(tbl[r].exp_avail));
      chk($sformatf("row%0d head", r), 32'(deq_ptr_o[0]), 32'(tbl[r].exp_head));
      chk($sformatf("row%0d tail", r), 32'(enq_ptr_o[0]), 32'(tbl[r].exp_tail));
      ep[0] = tbl[r].exp_pay0; ep[1] = tbl[r].exp_pay1;
      ep[2] = tbl[r].exp_pay2; ep[3] = tbl[r].exp_pay3;
      for (int i = 0; i < DW; i++) begin
        if (tbl[r].exp_vld[i]) chk($sformatf("row%0d pay%0d", r, i), dequeue_payload_o[i], ep[i]);
      end
    end

    // Streaming wrap with a scoreboard queue.
    clear_in();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    head_m = '0; tail_m = '0; nenq = 0; nxt = 32'h1000;
    for (int c = 0; c < 16; c++) begin
      cnt = sb.size();
      enqueue_vld_i = (c < 10) ? 4'hF : 4'h0;
      dequeue_rdy_i = (c >= 4) ? 4'hF : 4'h0;
      for (int i = 0; i < EW; i++) enqueue_payload_i[i] = nxt + 32'(i);
      #1;
      rdy_m = (16 - cnt >= 4) ? 4'hF : 4'h0;
      for (int i = 0; i < DW; i++) vld_m[i] = (cnt > i);
      chk($sformatf("wrap c%0d rdy", c), 32'(enqueue_rdy_o), 32'(rdy_m));
      chk($sformatf("wrap c%0d vld", c), 32'(dequeue_vld_o), 32'(vld_m));
      chk($sformatf("wrap c%0d avail", c), 32'(avail_cnt_o), 32'(16 - cnt));
      chk($sformatf("wrap c%0d head", c), 32'(deq_ptr_o[0]), 32'(head_m));
      chk($sformatf("wrap c%0d tail", c), 32'(enq_ptr_o[0]), 32'(tail_m));
      for (int i = 0; i < DW; i++) begin
        if (i < cnt) chk($sformatf("wrap c%0d pay%0d", c, i), dequeue_payload_o[i], sb[i]);
      end
      if (nenq == 20) chk("wrap tail after 20", 32'(enq_ptr_o[0]), 32'h14);
      @(negedge clk);
      pops = (c >= 4) ? ((cnt < 4) ? cnt : 4) : 0;
      for (int i = 0; i < pops; i++) void'(sb.pop_front());
      head_m = head_m + 5'(pops);
      if (c < 10 && rdy_m == 4'hF) begin
        for (int i = 0; i < EW; i++) sb.push_back(nxt + 32'(i));
        nxt = nxt + 32'd4;
        tail_m = tail_m + 5'd4;
        nenq = nenq + 4;
      end
    end
    chk("wrap drained avail", 32'(avail_cnt_o), 32'd16);
    chk("wrap final head", 32'(deq_ptr_o[0]), 32'h04);

    // Full queue, then flush with every other operation active.
    clear_in();
    for (int c = 0; c < 4; c++) begin
      enqueue_vld_i = 4'hF;
      for (int i = 0; i < EW; i++) enqueue_payload_i[i] = 32'h2000 + 32'(4 * c + i);
      @(negedge clk);
    end
    clear_in();
    #1;
    chk("full avail", 32'(avail_cnt_o), 32'd0);
    chk("full rdy", 32'(enqueue_rdy_o), 32'h0);
    chk("full vld", 32'(dequeue_vld_o), 32'hF);
    chk("full pay0", dequeue_payload_o[0], 32'h2000);
    flush_i = 1'b1; enqueue_vld_i = 4'hF; dequeue_rdy_i = 4'hF;
    upd_vld_i = 2'b11; upd_ptr_i[0] = 5'h04; upd_ptr_i[1] = 5'h05;
    rollback_vld_i = 1'b1; rollback_ptr_i = 5'h04;
    #1;
    chk("flush rdy", 32'(enqueue_rdy_o), 32'h0);
    @(negedge clk);
    clear_in();
    #1;
    chk_reset_state("flush");

    // Reset in the middle of traffic.
    for (int c = 0; c < 2; c++) begin
      enqueue_vld_i = 4'hF;
      for (int i = 0; i < EW; i++) enqueue_payload_i[i] = 32'h3000 + 32'(4 * c + i);
      @(negedge clk);
    end
    #1;
    chk("pre-rst avail", 32'(avail_cnt_o), 32'd8);
    rst = 1'b1; dequeue_rdy_i = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    chk_reset_state("midrst");
    enqueue_vld_i = 4'h1;
    enqueue_payload_i[0] = 32'h4000;
    @(negedge clk);
    clear_in();
    #1;
    chk("post-rst vld", 32'(dequeue_vld_o), 32'h1);
    chk("post-rst pay0", dequeue_payload_o[0], 32'h4000);
    chk("post-rst avail", 32'(avail_cnt_o), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
